// File: rtl/ccip_tx_queue.sv
// ccip_tx_queue: elastic buffer between the RPC core and the CCI-P DMA engine
// on the NIC-to-CPU write-back path. Responses are queued with their flow ID
// and released one per cycle while the datapath is started and CCI-P
// channel 1 has room.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   start              datapath enable; gates pops only
//   flush              single-cycle pulse; discards every queued entry
//   rpc_in*            push side from the RPC core (payload, valid, flow ID)
//   in_ready           registered "upstream may push" hint
//   ccip_tx_ready      CCI-P channel 1 not almost full
//   rpc_out*           pop side to the DMA engine (one-cycle valid pulses)
//   occupancy          entries currently stored
//   drop_cnt           saturating count of pushes rejected while full
//   overflow           sticky flag, set on the first rejected push
module ccip_tx_queue #(
  parameter int unsigned LMAX_NUM_OF_FLOWS = 1,
  parameter int unsigned LDEPTH            = 3,
  parameter int unsigned IN_SLACK          = 2,
  parameter type         RpcIf             = logic [63:0]
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         flush,
  input  logic [$bits(RpcIf)-1:0]      rpc_in,
  input  logic                         rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
  output logic                         in_ready,
  input  logic                         ccip_tx_ready,
  output logic [$bits(RpcIf)-1:0]      rpc_out,
  output logic                         rpc_out_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  output logic [LDEPTH:0]              occupancy,
  output logic [31:0]                  drop_cnt,
  output logic                         overflow
);

  localparam int unsigned RPC_W   = $bits(RpcIf);
  localparam int unsigned FLOW_W  = LMAX_NUM_OF_FLOWS;
  localparam int unsigned ENTRY_W = FLOW_W + RPC_W;
  localparam int unsigned DEPTH   = 1 << LDEPTH;
  localparam int unsigned PTR_W   = LDEPTH;
  localparam int unsigned CNT_W   = LDEPTH + 1;
  localparam int unsigned READY_LIMIT = DEPTH - IN_SLACK;

  // Entry storage; {flow_id, payload}. Deliberately not reset.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              rpc_out_valid_q, rpc_out_valid_d;
  logic [RPC_W-1:0]  rpc_out_q, rpc_out_d;
  logic [FLOW_W-1:0] rpc_flow_id_out_q, rpc_flow_id_out_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic               full_c;
  logic               empty_c;
  logic               push_c;
  logic               drop_c;
  logic               pop_c;
  logic [ENTRY_W-1:0] rd_entry_c;

  // Status decode from the registered count; a push against a full queue is
  // rejected even if a pop frees a slot in the same cycle (no pass-through).
  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign empty_c    = (count_q == '0);
  assign push_c     = rpc_in_valid && !full_c && !flush;
  assign drop_c     = rpc_in_valid && full_c && !flush;
  assign pop_c      = start && ccip_tx_ready && !empty_c && !flush;
  assign rd_entry_c = mem_q[rd_ptr_q];

  // Next-state logic for pointers, count, output stage and status.
  always_comb begin
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    rpc_out_valid_d   = 1'b0;
    rpc_out_d         = rpc_out_q;
    rpc_flow_id_out_d = rpc_flow_id_out_q;
    drop_cnt_d        = drop_cnt_q;
    overflow_d        = overflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        rpc_out_valid_d   = 1'b1;
        rpc_out_d         = rd_entry_c[RPC_W-1:0];
        rpc_flow_id_out_d = rd_entry_c[ENTRY_W-1:RPC_W];
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 32'hFFFF_FFFF) begin
        drop_cnt_d = drop_cnt_q + 32'd1;
      end
    end

    // Threshold leaves IN_SLACK free slots to absorb one cycle of upstream lag.
    in_ready_d = (count_d <= CNT_W'(READY_LIMIT));
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      in_ready_q        <= 1'b1;
      rpc_out_valid_q   <= 1'b0;
      rpc_out_q         <= '0;
      rpc_flow_id_out_q <= '0;
      drop_cnt_q        <= '0;
      overflow_q        <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      in_ready_q        <= in_ready_d;
      rpc_out_valid_q   <= rpc_out_valid_d;
      rpc_out_q         <= rpc_out_d;
      rpc_flow_id_out_q <= rpc_flow_id_out_d;
      drop_cnt_q        <= drop_cnt_d;
      overflow_q        <= overflow_d;
    end
  end

  // Payload RAM write port.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {rpc_flow_id_in, rpc_in};
    end
  end

  assign in_ready        = in_ready_q;
  assign rpc_out         = rpc_out_q;
  assign rpc_out_valid   = rpc_out_valid_q;
  assign rpc_flow_id_out = rpc_flow_id_out_q;
  assign occupancy       = count_q;
  assign drop_cnt        = drop_cnt_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_ccip_tx_queue.sv
// Testbench for ccip_tx_queue: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model.
module tb_ccip_tx_queue;

  localparam int unsigned LF    = 1;
  localparam int unsigned LD    = 3;
  localparam int unsigned SLACK = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RPC_W = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             flush;
  logic [RPC_W-1:0] rpc_in;
  logic             rpc_in_valid;
  logic [LF-1:0]    rpc_flow_id_in;
  logic             in_ready;
  logic             ccip_tx_ready;
  logic [RPC_W-1:0] rpc_out;
  logic             rpc_out_valid;
  logic [LF-1:0]    rpc_flow_id_out;
  logic [LD:0]      occupancy;
  logic [31:0]      drop_cnt;
  logic             overflow;

  ccip_tx_queue #(
    .LMAX_NUM_OF_FLOWS(LF),
    .LDEPTH(LD),
    .IN_SLACK(SLACK),
    .RpcIf(logic [RPC_W-1:0])
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .flush(flush),
    .rpc_in(rpc_in),
    .rpc_in_valid(rpc_in_valid),
    .rpc_flow_id_in(rpc_flow_id_in),
    .in_ready(in_ready),
    .ccip_tx_ready(ccip_tx_ready),
    .rpc_out(rpc_out),
    .rpc_out_valid(rpc_out_valid),
    .rpc_flow_id_out(rpc_flow_id_out),
    .occupancy(occupancy),
    .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: a FIFO of entries plus the observable status.
  typedef struct {
    logic [LF-1:0]    f;
    logic [RPC_W-1:0] d;
  } ent_t;

  ent_t             mq[$];
  logic             m_valid;
  logic [RPC_W-1:0] m_out;
  logic [LF-1:0]    m_flow;
  logic [31:0]      m_drops;
  logic             m_ovf;
  logic             m_ready;

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_out   = '0;
    m_flow  = '0;
    m_drops = '0;
    m_ovf   = 1'b0;
    m_ready = 1'b1;
  endtask

  // Apply current inputs to the model, then advance one clock and settle.
  task automatic tick();
    ent_t e;
    bit   full;
    full = (mq.size() == DEPTH);
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      if (rpc_in_valid && full) begin
        if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
        m_ovf = 1'b1;
      end
      if (start && ccip_tx_ready && mq.size() != 0) begin
        e       = mq.pop_front();
        m_valid = 1'b1;
        m_out   = e.d;
        m_flow  = e.f;
      end else begin
        m_valid = 1'b0;
      end
      if (rpc_in_valid && !full) begin
        e.f = rpc_flow_id_in;
        e.d = rpc_in;
        mq.push_back(e);
      end
    end
    m_ready = (mq.size() <= DEPTH - SLACK);
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [LF-1:0] f, input logic [RPC_W-1:0] d);
    rpc_in_valid   = 1'b1;
    rpc_flow_id_in = f;
    rpc_in         = d;
  endtask

  task automatic no_push();
    rpc_in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; ccip_tx_ready = 1'b0;
    rpc_in = '0; rpc_in_valid = 1'b0; rpc_flow_id_in = '0;
    model_reset();
    #12;
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rpc_out_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (drop_cnt !== 32'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (rpc_out !== 64'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", rpc_out); end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; ccip_tx_ready = 1'b1;
    tick();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b exp=0", rpc_out_valid); end
  endtask

  task automatic test_single();
    start = 1'b1; ccip_tx_ready = 1'b1;
    push_in(1'b1, 64'hA5);
    tick();
    no_push();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL single_c1_valid got=%b exp=0", rpc_out_valid); end
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL single_c1_occ got=%0d exp=1", occupancy); end
    tick();
    total++; if (rpc_out_valid !== 1'b1) begin bad++; $display("FAIL single_c2_valid got=%b exp=1", rpc_out_valid); end
    total++; if (rpc_out !== 64'hA5) begin bad++; $display("FAIL single_out got=%h exp=a5", rpc_out); end
    total++; if (rpc_flow_id_out !== 1'b1) begin bad++; $display("FAIL single_flow got=%b exp=1", rpc_flow_id_out); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL single_c2_occ got=%0d exp=0", occupancy); end
    tick();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL single_c3_valid got=%b exp=0", rpc_out_valid); end
  endtask

  task automatic test_fill_overflow();
    start = 1'b1; ccip_tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push_in(1'((i - 1) % 2), 64'(i));
      tick();
      total++; if (occupancy !== 4'(i)) begin bad++; $display("FAIL fill_occ i=%0d got=%0d exp=%0d", i, occupancy, i); end
      total++; if (in_ready !== (i <= 6)) begin bad++; $display("FAIL fill_in_ready i=%0d got=%b exp=%b", i, in_ready, (i <= 6)); end
    end
    push_in(1'b0, 64'h99);
    tick();
    no_push();
    total++; if (drop_cnt !== 32'd1) begin bad++; $display("FAIL fill_drop got=%0d exp=1", drop_cnt); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL fill_full_occ got=%0d exp=8", occupancy); end
    ccip_tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (rpc_out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, rpc_out_valid); end
      total++; if (rpc_out !== 64'(i)) begin bad++; $display("FAIL drain_out i=%0d got=%0d exp=%0d", i, rpc_out, i); end
      total++; if (rpc_flow_id_out !== 1'((i - 1) % 2)) begin bad++; $display("FAIL drain_flow i=%0d got=%b", i, rpc_flow_id_out); end
    end
    tick();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL drain_end_valid got=%b exp=0", rpc_out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] drops0;
    drops0 = m_drops;
    start = 1'b1; ccip_tx_ready = 1'b1;
    push_in(1'b0, 64'd100);
    tick();
    for (int k = 1; k <= 20; k++) begin
      push_in(1'(k), 64'(100 + k));
      tick();
      total++; if (rpc_out_valid !== 1'b1 || rpc_out !== 64'(100 + k - 1)) begin
        bad++; $display("FAIL b2b_out k=%0d got=%b/%0d exp=1/%0d", k, rpc_out_valid, rpc_out, 100 + k - 1);
      end
      total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL b2b_occ k=%0d got=%0d exp=1", k, occupancy); end
    end
    no_push();
    tick();
    total++; if (rpc_out !== 64'd120 || rpc_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_last got=%b/%0d exp=1/120", rpc_out_valid, rpc_out); end
    total++; if (drop_cnt !== drops0) begin bad++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, drops0); end
    tick();
  endtask

  task automatic test_flush();
    logic [31:0] drops0;
    drops0 = m_drops;
    start = 1'b1; ccip_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_in(1'($urandom), {$urandom, $urandom});
      tick();
    end
    total++; if (occupancy !== 4'd5) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=5", occupancy); end
    push_in(1'b1, 64'hDEAD);
    flush = 1'b1; ccip_tx_ready = 1'b1;
    tick();
    no_push();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", rpc_out_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (drop_cnt !== drops0) begin bad++; $display("FAIL flush_drop got=%0d exp=%0d", drop_cnt, drops0); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL flush_after_valid got=%b exp=0", rpc_out_valid); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; ccip_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_in(1'b0, 64'(200 + i));
      tick();
    end
    no_push();
    ccip_tx_ready = 1'b1;
    tick();
    total++; if (rpc_out_valid !== 1'b1 || occupancy !== 4'd3) begin bad++; $display("FAIL areset_pre got=%b/%0d exp=1/3", rpc_out_valid, occupancy); end
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", rpc_out_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL areset_occ got=%0d exp=0", occupancy); end
    total++; if (drop_cnt !== 32'd0 || overflow !== 1'b0) begin bad++; $display("FAIL areset_status got=%0d/%b exp=0/0", drop_cnt, overflow); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rpc_out_valid !== 1'b0 || occupancy !== 4'd0) begin bad++; $display("FAIL areset_after i=%0d got=%b/%0d exp=0/0", i, rpc_out_valid, occupancy); end
    end
  endtask

  task automatic test_start_gate();
    start = 1'b0; ccip_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_in(1'(i), 64'(300 + i));
      tick();
      total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL gate_push_valid i=%0d got=%b exp=0", i, rpc_out_valid); end
    end
    no_push();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rpc_out_valid !== 1'b0 || occupancy !== 4'd4) begin bad++; $display("FAIL gate_hold i=%0d got=%b/%0d exp=0/4", i, rpc_out_valid, occupancy); end
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (rpc_out_valid !== 1'b1 || rpc_out !== 64'(300 + i) || rpc_flow_id_out !== 1'(i)) begin
        bad++; $display("FAIL gate_release i=%0d got=%b/%0d exp=1/%0d", i, rpc_out_valid, rpc_out, 300 + i);
      end
    end
    tick();
    total++; if (rpc_out_valid !== 1'b0) begin bad++; $display("FAIL gate_end_valid got=%b exp=0", rpc_out_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rpc_in_valid   = ($urandom_range(2) != 0);
      rpc_flow_id_in = 1'($urandom);
      rpc_in         = {$urandom, $urandom};
      flush          = ($urandom_range(39) == 0);
      start          = ($urandom_range(7) != 0);
      ccip_tx_ready  = (c < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      tick();
      total++; if (rpc_out_valid !== m_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, rpc_out_valid, m_valid); end
      total++; if (rpc_out !== m_out) begin bad++; $display("FAIL rand_out c=%0d got=%h exp=%h", c, rpc_out, m_out); end
      total++; if (rpc_flow_id_out !== m_flow) begin bad++; $display("FAIL rand_flow c=%0d got=%b exp=%b", c, rpc_flow_id_out, m_flow); end
      total++; if (occupancy !== 4'(mq.size())) begin bad++; $display("FAIL rand_occ c=%0d got=%0d exp=%0d", c, occupancy, mq.size()); end
      total++; if (in_ready !== m_ready) begin bad++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, m_ready); end
      total++; if (drop_cnt !== m_drops) begin bad++; $display("FAIL rand_drop c=%0d got=%0d exp=%0d", c, drop_cnt, m_drops); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf); end
    end
    no_push();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_start_gate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ccip_tx_queue.md
Name: ccip_tx_queue

Overview:
- Elastic buffer that sits directly upstream of the CCI-P DMA engine on the NIC-to-CPU write-back path.
- Accepts RPC responses and their flow IDs from the RPC core, then holds them while CCI-P channel 1 is almost full.
- Releases exactly one entry per cycle into the DMA engine's rpc_in/rpc_in_valid/rpc_flow_id_in inputs, only while ccip_tx_ready is high.
- Reports occupancy, dropped responses and overflow to the NIC status registers.

Parameters:
LMAX_NUM_OF_FLOWS, 1, width of the flow ID field
LDEPTH, 3, log2 of queue depth (DEPTH = 2**LDEPTH entries)
IN_SLACK, 2, free entries still guaranteed when in_ready deasserts (1 <= IN_SLACK < DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  datapath enable; pops occur only while high
flush  in  1  single-cycle pulse; discards all queued entries
rpc_in  in  $bits(RpcIf)  response payload from the RPC core
rpc_in_valid  in  1  payload valid (push request)
rpc_flow_id_in  in  LMAX_NUM_OF_FLOWS  flow ID of the payload
in_ready  out  1  upstream may push; registered
ccip_tx_ready  in  1  downstream CCI-P channel 1 not almost full
rpc_out  out  $bits(RpcIf)  payload to the DMA engine
rpc_out_valid  out  1  one-cycle pulse per released entry
rpc_flow_id_out  out  LMAX_NUM_OF_FLOWS  flow ID of the released entry
occupancy  out  LDEPTH+1  entries currently stored
drop_cnt  out  32  saturating count of rejected pushes
overflow  out  1  sticky; set on the first rejected push

Behaviour:
Reset:
- Asserting reset (low) immediately clears wr_ptr, rd_ptr, count, rpc_out_valid, rpc_out, rpc_flow_id_out, drop_cnt and overflow.
- in_ready resets to 1.
- The payload RAM is not reset.
- Reset asserted mid-operation discards all entries. No rpc_out_valid appears in the cycle after reset is released.

Storage:
- DEPTH-entry array of {flow_id, payload}.
- LDEPTH-bit read and write pointers wrap naturally modulo DEPTH.
- count is LDEPTH+1 bits. full = (count == DEPTH), empty = (count == 0).

Push:
- Accepted when rpc_in_valid && !full && !flush.
- The entry is written at wr_ptr, and wr_ptr increments.
- When rpc_in_valid && full: the entry is dropped, drop_cnt increments (saturating at 0xFFFFFFFF), and overflow sets to 1. overflow stays set until reset.
- A push presented while flush is high is discarded silently. It is not counted in drop_cnt.

Pop:
- pop = start && ccip_tx_ready && !empty && !flush.
- On the next edge: rpc_out and rpc_flow_id_out load the entry at rd_ptr, rpc_out_valid becomes 1, and rd_ptr increments.
- When there is no pop, rpc_out_valid is 0. rpc_out and rpc_flow_id_out hold their last values.
- Downstream never back-pressures: each valid pulse is consumed.
- Pop uses the registered count, so an entry pushed in cycle N can pop in cycle N+1 at the earliest. rpc_out_valid for that entry appears in cycle N+2 (minimum latency: 2 cycles).

Simultaneous events:
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push while full with a pop in the same cycle: the push is still rejected, because full is evaluated from the registered count. There is no pass-through.
- flush takes priority over push and pop. Pointers and count clear on the next edge, and rpc_out_valid is 0 in that cycle.

Flow control:
- in_ready is registered: in_ready <= (next_count <= DEPTH - IN_SLACK).
- Upstream honouring in_ready with at most one cycle of lag never overflows.

Status:
- occupancy equals count.
- While start is low, entries accumulate but are never released.

Test Plan:
- Reset release, start=1, ccip_tx_ready=1, push flow 1 with payload 0xA5 in cycle 0 -> rpc_out_valid in cycle 2 with rpc_flow_id_out=1 and rpc_out=0xA5; occupancy returns to 0.
- start=1, ccip_tx_ready=0, push 8 entries (flow IDs alternating 0/1, payloads 1..8) with DEPTH=8 -> in_ready falls after occupancy reaches 6; a 9th push gives drop_cnt=1 and overflow=1; raising ccip_tx_ready then emits payloads 1..8 in order on 8 consecutive cycles.
- Continuous push and pop with ccip_tx_ready=1 for 20 cycles -> occupancy stable at 1, 20 outputs in order, pointer wrap-around exercised, drop_cnt=0.
- Queue holding 5 entries, flush pulsed together with a push and ccip_tx_ready=1 -> no rpc_out_valid in that cycle, occupancy=0 afterwards, drop_cnt unchanged, in_ready=1.
- Queue holding 3 entries, reset asserted asynchronously between clock edges -> rpc_out_valid and occupancy drop to 0 immediately; after release nothing is emitted and drop_cnt=0.
- start=0 with 4 entries pushed and ccip_tx_ready=1 -> no output while start is low; raising start releases all 4 on consecutive cycles.
